neuron_mac: RTL

//  Serial multiply-accumulate neuron that sits directly upstream of the tanh LUT.
//  It accepts NUM_INPUTS signed Q(N-1-Q).Q samples and weights, one pair per handshake.
//  It adds a bias, rescales the sum back to Q format and saturates it to N bits.
//  It presents the result as a registered activation-table address.

---
 rtl/neuron_mac.sv | 73 +++++++
 1 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: serial MAC neuron producing a saturated Q-format activation-table address
module neuron_mac #(
    parameter int N          = 8,
    parameter int Q          = 7,
    parameter int NUM_INPUTS = 4,
    parameter int ACC_W      = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [N-1:0] in_weight,
    input  logic [N-1:0] bias,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] act_addr,
    output logic         sat_flag
);
    localparam int CW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);
    localparam int MAXI = 2 ** (N - 1) - 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(MAXI);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-MAXI - 1);
    typedef enum logic [1:0] {S_ACC, S_SAT, S_OUT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic signed [2*N-1:0] p;
    logic signed [ACC_W-1:0] acc, prod, sum, r;
    logic accept, hi, lo;
    assign p      = $signed(in_data) * $signed(in_weight);
    assign prod   = {{(ACC_W-2*N){p[2*N-1]}}, p};
    assign sum    = acc + ({{(ACC_W-N){bias[N-1]}}, bias} <<< Q);
    assign r      = sum >>> Q;
    assign hi     = r > MAXV;
    assign lo     = r < MINV;
    assign accept = in_valid & in_ready;
    always_ff @(posedge clk) begin
        if (rst) state <= S_ACC;
        else     state <= state_n;
    end
    always_comb begin
        state_n = (state == S_ACC && accept && cnt == LAST) ? S_SAT :
                  (state == S_SAT)                          ? S_OUT :
                  (state == S_OUT && out_ready)             ? S_ACC : state;
    end
    always_comb begin
        in_ready = !rst && state == S_ACC;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            act_addr  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept) begin
                acc <= acc + prod;
                cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            end
            if (state == S_SAT) begin
                out_valid <= 1'b1;
                act_addr  <= hi ? MAXV[N-1:0] : lo ? MINV[N-1:0] : r[N-1:0];
                sat_flag  <= hi || lo;
            end
            if (state == S_OUT && out_ready) begin
                out_valid <= 1'b0;
                acc       <= '0;
            end
        end
    end
endmodule
